// File: rtl/spi_word_rx.sv
// spi_word_rx: SPI word receiver for the audio datapath.
//
// Deserialises MSB-first framed words from an asynchronous SPI port
// (spi_cs_n, spi_sclk, spi_sdin) into parallel words on clk. Completed words
// go through a 2-entry FIFO with a valid/ready read port.
//
// Parameters
//   WIDTH        bits per frame (2..32)
//   SAMPLE_RISE  1: sample sdin on sclk rising edge, 0: on falling edge
//
// Ports
//   clk        system clock (sclk must be <= clk/4)
//   rst_n      synchronous active-low reset
//   spi_cs_n   frame select, active-low, asynchronous
//   spi_sclk   serial clock, asynchronous
//   spi_sdin   serial data, MSB first
//   rd_data    word at buffer head, meaningful while rd_valid
//   rd_valid   buffer non-empty
//   rd_ready   consumer accepts head word when rd_valid && rd_ready
//   frame_err  1-cycle pulse: frame closed with a bit count other than WIDTH
//   overrun    1-cycle pulse: complete word dropped because buffer was full

module spi_word_rx #(
    parameter int WIDTH       = 16,
    parameter bit SAMPLE_RISE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_cs_n,
    input  logic             spi_sclk,
    input  logic             spi_sdin,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    // ------------------------------------------------------------------
    // Input synchronisers. Bit 0 = cs_n, bit 1 = sclk, bit 2 = sdin.
    // All three lines share the same two-stage delay so sd_s lines up with
    // the sclk_s edge that samples it. cs_n resets to 0 (not idle) so a
    // frame still running when reset releases is never mistaken for a new
    // one: the FSM must first see a real high level on cs_n.
    // ------------------------------------------------------------------
    logic [2:0] line_in;
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [1:0] prev_q;   // previous cs_s / sclk_s for edge detection

    assign line_in = {spi_sdin, spi_sclk, spi_cs_n};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q[1:0];
        end
    end

    logic cs_s, sclk_s, sd_s;
    logic cs_fall, cs_rise, sclk_edge, sample;

    assign cs_s   = sync_q[0];
    assign sclk_s = sync_q[1];
    assign sd_s   = sync_q[2];

    assign cs_fall   = ~cs_s & prev_q[0];
    assign cs_rise   = cs_s & ~prev_q[0];
    assign sclk_edge = SAMPLE_RISE ? (sclk_s & ~prev_q[1]) : (~sclk_s & prev_q[1]);
    assign sample    = sclk_edge & ~cs_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_SHIFT     = 2'd2,
        S_COMMIT    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               push_req;
    logic               frame_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_WAIT_IDLE: begin
                if (cs_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cs_fall) begin
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    state_d = S_COMMIT;
                end else if (sample) begin
                    shift_d = {shift_q[WIDTH-2:0], sd_s};
                    // Saturating one past WIDTH is enough to flag long frames.
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMMIT: begin
                if (bit_cnt_q == CNT_FULL) begin
                    push_req = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_WAIT_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO. A pop in the same cycle as a push into a full
    // buffer frees the slot, so the push is accepted.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             pop, push_ok, overrun_d;
    logic             frame_err_q, overrun_q;

    assign pop       = (count_q != 2'd0) & rd_ready;
    assign push_ok   = push_req & ((count_q != 2'd2) | pop);
    assign overrun_d = push_req & ~push_ok;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign rd_valid  = (count_q != 2'd0);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// tb_spi_word_rx: directed bench for spi_word_rx.
//
// Channel 0 is a receiver sampling on sclk rising edges; channel 1 samples on
// falling edges and is driven by a DAC-style transmitter model (data changes
// on sclk rise). A transaction-level model predicts, from the moment cs_n is
// raised, the cycle at which each frame commits (4 clk edges later) and keeps
// a word queue per channel; every cycle the DUT outputs are compared to it.

`timescale 1ns/1ps
module tb_spi_word_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  cs_n, sclk, sdin, rd_ready;
    logic [1:0]  rd_valid, frame_err, overrun;
    logic [15:0] rd_data0, rd_data1;

    spi_word_rx #(.WIDTH(16), .SAMPLE_RISE(1'b1)) u_dut_rise (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]), .spi_sdin(sdin[0]),
        .rd_data(rd_data0), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
        .frame_err(frame_err[0]), .overrun(overrun[0])
    );

    spi_word_rx #(.WIDTH(16), .SAMPLE_RISE(1'b0)) u_dut_fall (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]), .spi_sdin(sdin[1]),
        .rd_data(rd_data1), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
        .frame_err(frame_err[1]), .overrun(overrun[1])
    );

    typedef struct {
        int          cyc;
        int          ch;
        bit          ok;
        logic [15:0] w;
    } ev_t;

    ev_t         evq[$];
    logic [15:0] mq [2][2];
    int          mcnt [2];
    bit          exp_err [2];
    bit          exp_ovr [2];
    int          cyc;
    int          total;
    int          bad;

    logic [15:0] got0[$];
    logic [15:0] got1[$];
    bit          last_valid [2];
    logic [15:0] last_data [2];
    int          dut_err_cnt [2];
    int          dut_ovr_cnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle model and compare process
    initial begin
        ev_t         ev;
        logic [15:0] dd;
        cyc   = 0;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; last_valid[i] = 0; last_data[i] = '0;
            dut_err_cnt[i] = 0; dut_ovr_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int ch = 0; ch < 2; ch++) begin
                exp_err[ch] = 0;
                exp_ovr[ch] = 0;
                if (!rst_n) begin
                    mcnt[ch] = 0;
                end else begin
                    if (last_valid[ch] && rd_ready[ch]) begin
                        if (ch == 0) got0.push_back(last_data[ch]);
                        else         got1.push_back(last_data[ch]);
                    end
                    if (mcnt[ch] > 0 && rd_ready[ch]) begin
                        mq[ch][0] = mq[ch][1];
                        mcnt[ch]--;
                    end
                end
            end
            if (rst_n && evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (!ev.ok)                exp_err[ev.ch] = 1;
                else if (mcnt[ev.ch] == 2) exp_ovr[ev.ch] = 1;
                else begin
                    mq[ev.ch][mcnt[ev.ch]] = ev.w;
                    mcnt[ev.ch]++;
                end
            end
            #1;
            for (int ch = 0; ch < 2; ch++) begin
                dd = (ch == 0) ? rd_data0 : rd_data1;
                chk($sformatf("rd_valid%0d", ch), 32'(rd_valid[ch]), 32'(mcnt[ch] > 0));
                if (mcnt[ch] > 0)
                    chk($sformatf("rd_data%0d", ch), 32'(dd), 32'(mq[ch][0]));
                chk($sformatf("frame_err%0d", ch), 32'(frame_err[ch]), 32'(exp_err[ch]));
                chk($sformatf("overrun%0d", ch), 32'(overrun[ch]), 32'(exp_ovr[ch]));
                if (frame_err[ch] === 1'b1) dut_err_cnt[ch]++;
                if (overrun[ch] === 1'b1)   dut_ovr_cnt[ch]++;
                last_valid[ch] = (rd_valid[ch] === 1'b1);
                last_data[ch]  = dd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drives happen on the falling clk edge)
    // ------------------------------------------------------------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input int ch);
        @(negedge clk);
        cs_n[ch] = 1'b0;
        clks(2);
    endtask

    task automatic frame_bits(input int ch, input logic [31:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (ch == 0) begin
                sdin[0] = d[i];
                clks(2);
                sclk[0] = 1'b1;
                clks(2);
                sclk[0] = 1'b0;
            end else begin
                sclk[1] = 1'b1;
                sdin[1] = d[i];
                clks(2);
                sclk[1] = 1'b0;
                clks(2);
            end
        end
    endtask

    task automatic frame_end(input int ch, input int n, input logic [15:0] w,
                             input bit sched, input int gap);
        ev_t ev;
        clks(2);
        cs_n[ch] = 1'b1;
        sdin[ch] = 1'b0;
        if (sched) begin
            ev.cyc = cyc + 4;
            ev.ch  = ch;
            ev.ok  = (n == 16);
            ev.w   = w;
            evq.push_back(ev);
        end
        clks(gap);
    endtask

    task automatic send(input int ch, input logic [31:0] d, input int n);
        frame_start(ch);
        frame_bits(ch, d, n);
        frame_end(ch, n, d[15:0], 1'b1, 6);
    endtask

    task automatic expect_word(input int ch, input logic [15:0] w);
        logic [15:0] g;
        int          sz;
        sz = (ch == 0) ? got0.size() : got1.size();
        if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL word%0d got=none want=%04h", ch, w);
        end else begin
            g = (ch == 0) ? got0.pop_front() : got1.pop_front();
            chk($sformatf("word%0d", ch), 32'(g), 32'(w));
        end
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int c;
        int err_before;
        rst_n    = 1'b0;
        cs_n     = 2'b11;
        sclk     = 2'b00;
        sdin     = 2'b00;
        rd_ready = 2'b11;
        clks(3);
        chk("reset_valid", 32'(rd_valid), 32'h0);
        chk("reset_data0", 32'(rd_data0), 32'h0);
        chk("reset_data1", 32'(rd_data1), 32'h0);
        chk("reset_err",   32'(frame_err), 32'h0);
        chk("reset_ovr",   32'(overrun), 32'h0);
        rst_n = 1'b1;
        clks(6);

        // Single frame
        send(0, 32'hA5C3, 16);
        clks(4);
        expect_word(0, 16'hA5C3);

        // Short, long, empty frames then a good one
        send(0, 32'h7FFF, 15);
        send(0, 32'h1FFFF, 17);
        send(0, 32'h0, 0);
        chk("short_long_errs", 32'(dut_err_cnt[0]), 32'd3);
        chk("short_long_nowords", 32'(got0.size()), 32'd0);
        send(0, 32'h0001, 16);
        clks(4);
        expect_word(0, 16'h0001);

        // Overrun on the third frame
        rd_ready[0] = 1'b0;
        send(0, 32'h1111, 16);
        send(0, 32'h2222, 16);
        send(0, 32'h3333, 16);
        chk("overrun_once", 32'(dut_ovr_cnt[0]), 32'd1);
        rd_ready[0] = 1'b1;
        clks(5);
        expect_word(0, 16'h1111);
        expect_word(0, 16'h2222);
        chk("overrun_drained", 32'(got0.size()), 32'd0);

        // Pop in the same cycle as the commit into a full buffer
        rd_ready[0] = 1'b0;
        send(0, 32'hAAAA, 16);
        send(0, 32'hBBBB, 16);
        frame_start(0);
        frame_bits(0, 32'hCCCC, 16);
        frame_end(0, 16, 16'hCCCC, 1'b1, 0);
        c = cyc;
        while (cyc < c + 3) clks(1);
        rd_ready[0] = 1'b1;
        clks(1);
        rd_ready[0] = 1'b0;
        clks(4);
        chk("simul_no_overrun", 32'(dut_ovr_cnt[0]), 32'd1);
        expect_word(0, 16'hAAAA);
        rd_ready[0] = 1'b1;
        clks(4);
        expect_word(0, 16'hBBBB);
        expect_word(0, 16'hCCCC);

        // Reset mid-frame, released while cs_n is still low
        err_before = dut_err_cnt[0];
        frame_start(0);
        frame_bits(0, 32'hA5, 8);
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
        frame_bits(0, 32'h5A, 8);
        frame_end(0, 16, 16'h0, 1'b0, 6);
        chk("reset_mid_no_err", 32'(dut_err_cnt[0]), 32'(err_before));
        chk("reset_mid_no_word", 32'(got0.size()), 32'd0);
        send(0, 32'hFFFF, 16);
        clks(4);
        expect_word(0, 16'hFFFF);

        // Loopback from the DAC-style transmitter, falling-edge receiver
        send(1, 32'h0000, 16);
        send(1, 32'h8001, 16);
        send(1, 32'h7FFE, 16);
        send(1, 32'hFFFF, 16);
        clks(4);
        expect_word(1, 16'h0000);
        expect_word(1, 16'h8001);
        expect_word(1, 16'h7FFE);
        expect_word(1, 16'hFFFF);
        chk("loop_err", 32'(dut_err_cnt[1]), 32'd0);
        chk("loop_ovr", 32'(dut_ovr_cnt[1]), 32'd0);
        chk("pending_events", 32'(evq.size()), 32'd0);

        clks(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
